// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes host words LSB-first into the config flip-flop chain and checksums the displaced tail bits
module ccff_chain_loader #(
  parameter int DATA_W = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              tail_parity,
  output logic [CNT_W-1:0]  bits_shifted
);
  localparam int RW = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] sreg;
  logic [RW-1:0] rem, nb;
  logic [31:0] left;
  logic last;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    left = 32'(CHAIN_LEN) - 32'(bits_shifted);
    nb = left < 32'(DATA_W) ? RW'(left) : RW'(DATA_W);
    last = rem == RW'(1);
    word_ready = state == LOAD;
    busy = state == LOAD || state == SHIFT;
    done = state == DONE;
    ccff_shift_en = state == SHIFT;
    ccff_head = state == SHIFT && sreg[0];
    state_nx = state == IDLE ? (start ? LOAD : IDLE) :
               state == LOAD ? (word_valid ? SHIFT : LOAD) :
               state == SHIFT ? (!last ? SHIFT : bits_shifted == CNT_W'(CHAIN_LEN - 1) ? DONE : LOAD) :
               IDLE;
  end
  // rem counts down the burst; the last shift of the chain exits straight to DONE
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sreg <= '0;
      rem <= '0;
      bits_shifted <= '0;
      tail_parity <= 1'b0;
    end else if (state == IDLE && start) begin
      bits_shifted <= '0;
      tail_parity <= 1'b0;
    end else if (state == LOAD && word_valid) begin
      sreg <= word_data;
      rem <= nb;
    end else if (state == SHIFT) begin
      sreg <= sreg >> 1;
      rem <= rem - RW'(1);
      bits_shifted <= bits_shifted + CNT_W'(1);
      tail_parity <= tail_parity ^ ccff_tail;
    end
endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Sequencing controller that loads configuration bits into the fabric's configuration flip-flop chain, which is built from the DFFSRQ cells inside the router-wrap slice tiles. It accepts configuration words from a host over a valid/ready handshake, serializes each word LSB-first onto the chain head with a one-cycle shift enable per bit, and stops after exactly CHAIN_LEN bits. It also returns an XOR checksum of the bits that leave the chain tail, which are the previous configuration contents.

## Interface
- DATA_W, 8, width of one host configuration word (≥2)
- CHAIN_LEN, 64, number of flip-flops in the chain (≥1)
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low; asserting low clears all state immediately
- start  input  1  begin a load; honoured only in IDLE
- word_valid  input  1  host word available
- word_data  input  DATA_W  host word; bit 0 is shifted first
- word_ready  output  1  controller accepts a word this cycle
- ccff_head  output  1  serial data driven into the chain head
- ccff_shift_en  output  1  chain shifts on this clock edge
- ccff_tail  input  1  chain tail output, the bit about to be shifted out
- busy  output  1  load in progress (LOAD or SHIFT)
- done  output  1  one-cycle pulse when the load completes
- tail_parity  output  1  XOR of all ccff_tail samples taken during the last load
- bits_shifted  output  CNT_W  number of bits shifted so far in the current or last load

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1: go to LOAD.
  - On that transition, clear bits_shifted and tail_parity.
  - word_ready=0.
- LOAD:
  - word_ready=1.
  - On word_valid&word_ready: capture word_data into shift register sreg.
  - Set the burst length nb = min(DATA_W, CHAIN_LEN − bits_shifted).
  - Go to SHIFT.
  - With no valid word, stay in LOAD indefinitely.
- SHIFT:
  - ccff_shift_en=1, ccff_head=sreg[0], word_ready=0.
  - Each cycle: sreg >>= 1; bits_shifted += 1; tail_parity ^= ccff_tail.
  - After nb cycles:
    - bits_shifted==CHAIN_LEN: go to DONE.
    - Otherwise: go to LOAD.
- DONE:
  - done=1 for one cycle.
  - Go to IDLE.
  - bits_shifted and tail_parity hold until the next start.
- Partial final word: when CHAIN_LEN is not a multiple of DATA_W, only the low nb bits of the last word are shifted and its upper bits are discarded.
- start outside IDLE is ignored. word_valid outside LOAD is ignored; the host must hold the word until word_ready.
- ccff_head=0 and ccff_shift_en=0 whenever the state is not SHIFT.

## Timing
- Reset values: state=IDLE, word_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, tail_parity=0, bits_shifted=0, sreg=0.
- Registered outputs; no combinational path from any input to any output.
- start sampled at edge N gives busy=1 and word_ready=1 in cycle N+1.
- Word accepted at edge M gives shift_en=1 in cycles M+1 … M+nb.
- Per-word cost: 1 LOAD cycle + nb SHIFT cycles when word_valid is held high.
- Full load with a continuously valid host takes CHAIN_LEN + ceil(CHAIN_LEN/DATA_W) cycles from the first LOAD cycle to the last SHIFT cycle; done asserts in the following cycle.
- ccff_tail is sampled on the same edge that shifts the chain, so it is the pre-shift tail value.
- Reset asserted mid-load: all outputs are cleared asynchronously and the chain is left partially written; software must restart.
- bits_shifted never exceeds CHAIN_LEN; the counter saturates logically because SHIFT exits exactly at CHAIN_LEN.

## Test plan
- Reset behaviour: with CHAIN_LEN=20 and DATA_W=8, hold reset=0 → every output is 0; release reset, wait 5 cycles with no start → outputs stay 0 and state stays IDLE.
- Full-word serialization: start, then word 0xA5 → ccff_head sequence 1,0,1,0,0,1,0,1 on 8 consecutive shift_en cycles, then word_ready=1 again, bits_shifted=8.
- Partial final word: with CHAIN_LEN=20, send 0xFF, 0x00, 0x3C → 8+8+4 shifts with last-word bits 0,0,1,1; done pulses exactly 1 cycle after the 20th shift; 0x3C upper bits are never driven.
- Host stall and ignored start: hold word_valid=0 in LOAD for 10 cycles → shift_en stays 0 and busy=1; start pulsed during SHIFT → no effect on sequence or count.
- Tail checksum: drive ccff_tail=1 on exactly 3 shift cycles of a 20-bit load → tail_parity=1; drive it on 4 cycles → tail_parity=0; a new start clears it.
- Reset mid-load: assert reset after 5 shifts → shift_en, busy and bits_shifted go to 0 immediately; after release, a new start performs a complete 20-bit load.
